// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bundle for one port of the data-memory arbiter.
// The requester drives valid/we/addr/wdata; the arbiter answers with ready/rsp/rdata/err.
interface dmem_arbiter_if #(
  parameter int M = 32
);
  logic         valid;
  logic         we;
  logic [M-1:0] addr;
  logic [M-1:0] wdata;
  logic         ready;
  logic         rsp;
  logic [M-1:0] rdata;
  logic         err;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp, rdata, err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (port 0)
// and the debug/loader (port 1); one transaction per three cycles, range-checked.
module dmem_arbiter #(
  parameter int N = 10,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  dmem_arbiter_if.slave core,
  dmem_arbiter_if.slave dbg,
  output logic [M-1:0] mem_addr,
  output logic [M-1:0] mem_din,
  output logic         mem_wr_en,
  output logic         mem_rd_en,
  input  logic [M-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t       state;
  logic         last;
  logic         owner;
  logic         we_reg;
  logic         err_reg;
  logic         core_rsp_reg;
  logic         dbg_rsp_reg;
  logic [M-1:0] addr_reg;
  logic [M-1:0] wdata_reg;

  logic         grant_valid;
  logic         grant;
  logic         sel_we;
  logic         sel_in_range;
  logic [M-1:0] sel_addr;
  logic [M-1:0] sel_wdata;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state == IDLE) begin
      if (core.valid && dbg.valid) begin
        grant_valid = 1'b1;
        grant       = ~last;
      end else if (core.valid) begin
        grant_valid = 1'b1;
      end else if (dbg.valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
    end
  end

  assign sel_we       = grant ? dbg.we    : core.we;
  assign sel_addr     = grant ? dbg.addr  : core.addr;
  assign sel_wdata    = grant ? dbg.wdata : core.wdata;
  assign sel_in_range = (sel_addr >> N) == '0;

  assign core.ready = grant_valid && !grant;
  assign dbg.ready  = grant_valid && grant;

  assign mem_addr = addr_reg;
  assign mem_din  = wdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      core_rsp_reg <= 1'b0;
      dbg_rsp_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant;
            last      <= grant;
            we_reg    <= sel_we;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            err_reg   <= !sel_in_range;
            // Strobes are registered so they are high for exactly the ISSUE cycle.
            mem_wr_en <= sel_in_range && sel_we;
            mem_rd_en <= sel_in_range && !sel_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wr_en    <= 1'b0;
          mem_rd_en    <= 1'b0;
          core_rsp_reg <= !owner;
          dbg_rsp_reg  <= owner;
          state        <= RESP;
        end
        RESP: begin
          core_rsp_reg <= 1'b0;
          dbg_rsp_reg  <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          mem_wr_en    <= 1'b0;
          mem_rd_en    <= 1'b0;
          core_rsp_reg <= 1'b0;
          dbg_rsp_reg  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Memory read data arrives in the RESP cycle, so it is forwarded rather than registered.
  assign core.rsp   = core_rsp_reg;
  assign core.err   = core_rsp_reg && err_reg;
  assign core.rdata = (core_rsp_reg && !we_reg && !err_reg) ? mem_dout : '0;
  assign dbg.rsp    = dbg_rsp_reg;
  assign dbg.err    = dbg_rsp_reg && err_reg;
  assign dbg.rdata  = (dbg_rsp_reg && !we_reg && !err_reg) ? mem_dout : '0;

endmodule
